// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and error codes for the UART command parser
package uart_pkg;

  // Frame assembly phases: wait for header, then CMD, LEN, payload bytes, checksum
  typedef enum logic [2:0] {
    S_HEAD,
    S_CMD,
    S_LEN,
    S_DATA,
    S_SUM
  } state_t;

  localparam logic [1:0] ERR_SUM    = 2'd1;
  localparam logic [1:0] ERR_LEN    = 2'd2;
  localparam logic [1:0] ERR_TMO    = 2'd3;

  localparam logic [7:0] DEF_HEADER = 8'hAA;

endpackage

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - inter-byte idle counter with single-cycle expiry pulse
module uart_idle_timer #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [31:0] LAST = 32'(CYCLES - 1);

  logic [31:0] cnt;

  // A clear in the expiry cycle wins, so a byte arriving right at the limit is not lost
  assign expire = run & ~clear & (cnt == LAST);

  // Count idle cycles while running; restart on clear, stop, or expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed command parser (HEADER CMD LEN PAYLOAD SUM); optional UART_CMD_TIMEOUT_EN idle timeout
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FRE    = 50,
  parameter int         MAX_LEN    = 8,
  parameter logic [7:0] HEADER     = DEF_HEADER,
  parameter int         TIMEOUT_US = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   recv_en,
  input  logic [7:0]             recv_data,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_code,
  output logic [3:0]             cmd_len,
  output logic [8*MAX_LEN-1:0]   cmd_payload,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
  localparam int unsigned TMO_CYCLES = CLK_FRE * TIMEOUT_US;

  state_t      state;
  state_t      state_nx;
  logic        recv_en_d;
  logic        byte_stb;
  logic [3:0]  idx;
  logic [3:0]  len_sh;
  logic [7:0]  code_sh;
  logic [7:0]  sum;
  logic [7:0]  pay_sh [MAX_LEN];
  logic        tmo_expire;
  logic        frame_ok;
  logic        err_fire;
  logic [1:0]  err_kind;

  // Remember the previous recv_en level so a long-held level yields one byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recv_en_d <= 1'b0;
    end else begin
      recv_en_d <= recv_en;
    end
  end

  assign byte_stb = recv_en & ~recv_en_d;
  assign busy     = (state != S_HEAD);

`ifdef UART_CMD_TIMEOUT_EN
  uart_idle_timer #(
    .CYCLES (TMO_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (byte_stb),
    .run    (busy),
    .expire (tmo_expire)
  );
  logic unused_cfg;
  assign unused_cfg = 1'b0;
`else
  assign tmo_expire = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^TMO_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HEAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection; an idle timeout only applies when no byte arrives that cycle
  always_comb begin
    state_nx = state;
    if (byte_stb) begin
      case (state)
        S_HEAD: if (recv_data == HEADER) state_nx = S_CMD;
        S_CMD:  state_nx = S_LEN;
        S_LEN: begin
          if (recv_data > MAX_LEN_B)   state_nx = S_HEAD;
          else if (recv_data == 8'd0)  state_nx = S_SUM;
          else                         state_nx = S_DATA;
        end
        S_DATA: if (idx == 4'(len_sh - 4'd1)) state_nx = S_SUM;
        S_SUM:  state_nx = S_HEAD;
        default: state_nx = S_HEAD;
      endcase
    end else if (tmo_expire) begin
      state_nx = S_HEAD;
    end
  end

  // Frame outcome for this cycle: accepted frame, or rejection with its cause
  always_comb begin
    frame_ok = 1'b0;
    err_fire = 1'b0;
    err_kind = ERR_SUM;
    if (byte_stb && state == S_SUM) begin
      if (recv_data == sum) begin
        frame_ok = 1'b1;
      end else begin
        err_fire = 1'b1;
        err_kind = ERR_SUM;
      end
    end else if (byte_stb && state == S_LEN && recv_data > MAX_LEN_B) begin
      err_fire = 1'b1;
      err_kind = ERR_LEN;
    end else if (tmo_expire) begin
      err_fire = 1'b1;
      err_kind = ERR_TMO;
    end
  end

  // Frame shadow registers, running checksum, and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      len_sh      <= '0;
      code_sh     <= '0;
      sum         <= '0;
      pay_sh      <= '{default: '0};
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
    end else begin
      cmd_valid <= frame_ok;
      err_valid <= err_fire;
      if (err_fire) begin
        err_code <= err_kind;
      end
      if (frame_ok) begin
        cmd_code <= code_sh;
        cmd_len  <= len_sh;
        for (int i = 0; i < MAX_LEN; i++) begin
          cmd_payload[8*i +: 8] <= pay_sh[i];
        end
      end
      if (byte_stb) begin
        case (state)
          S_HEAD: begin
            if (recv_data == HEADER) begin
              sum    <= '0;
              idx    <= '0;
              len_sh <= '0;
              pay_sh <= '{default: '0};
            end
          end
          S_CMD: begin
            code_sh <= recv_data;
            sum     <= recv_data;
          end
          S_LEN: begin
            if (recv_data <= MAX_LEN_B) begin
              len_sh <= recv_data[3:0];
              sum    <= sum + recv_data;
            end
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) pay_sh[i] <= recv_data;
            end
            sum <= sum + recv_data;
            idx <= idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized byte-stream bench with frame-level reference model
module tb_uart_cmd_parser;

  localparam int         MAXL = 8;
  localparam logic [7:0] HDR  = 8'hAA;

  logic        clk = 1'b0;
  logic        rst;
  logic        recv_en;
  logic [7:0]  recv_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  uart_cmd_parser #(
    .CLK_FRE    (1),
    .MAX_LEN    (MAXL),
    .HEADER     (HDR),
    .TIMEOUT_US (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .recv_en     (recv_en),
    .recv_data   (recv_data),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_cmd;
    logic [7:0]  code;
    logic [3:0]  len;
    logic [63:0] pay;
    logic [1:0]  ecode;
    int          due;
  } ev_t;

  ev_t         sb[$];
  ev_t         cur;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_send = 0;
  logic [7:0]  hold_code = '0;
  logic [3:0]  hold_len = '0;
  logic [63:0] hold_pay = '0;
  logic [1:0]  hold_err = '0;
  bit          exp_busy = 0;
  bit          busy_next = 0;
  int          busy_at = -1;
  bit          m_in = 0;
  logic [7:0]  m_buf[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: collect bytes after a header, judge the frame once LEN or the full length is known
  task automatic model_byte(input logic [7:0] b, input int due);
    ev_t        e;
    logic [7:0] sm;
    logic [7:0] lb;
    int         n;
    if (!m_in) begin
      if (b == HDR) begin
        m_in = 1;
        m_buf.delete();
      end
    end else begin
      m_buf.push_back(b);
      n = m_buf.size();
      lb = (n >= 2) ? m_buf[1] : 8'd0;
      e.is_cmd = 0; e.code = '0; e.len = '0; e.pay = '0; e.ecode = '0; e.due = due;
      if (n == 2 && lb > MAXL) begin
        e.ecode = 2'd2;
        sb.push_back(e);
        m_in = 0;
      end else if (n >= 2 && n == int'(lb) + 3) begin
        sm = '0;
        for (int k = 0; k < n - 1; k++) sm = sm + m_buf[k];
        if (sm == m_buf[n-1]) begin
          e.is_cmd = 1;
          e.code = m_buf[0];
          e.len = lb[3:0];
          for (int k = 0; k < int'(lb); k++) e.pay[8*k +: 8] = m_buf[2+k];
        end else begin
          e.ecode = 2'd1;
        end
        sb.push_back(e);
        m_in = 0;
      end
    end
    busy_next = m_in;
    busy_at = due;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #2;
    recv_data = b;
    recv_en = 1'b1;
    last_send = cyc;
    model_byte(b, cyc + 2);
    repeat (hold) @(posedge clk);
    #2;
    recv_en = 1'b0;
    recv_data = 8'($urandom);
    repeat ($urandom_range(1, 2)) @(posedge clk);
  endtask

  task automatic send_list(input logic [7:0] bl[$], input int hold);
    foreach (bl[i]) send_byte(bl[i], hold == 0 ? int'($urandom_range(1, 3)) : hold);
  endtask

  task automatic send_frame(input logic [7:0] code, input int len, input bit bad);
    logic [7:0] bl[$];
    logic [7:0] s;
    logic [7:0] d;
    s = code + 8'(len);
    bl.push_back(HDR); bl.push_back(code); bl.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      s = s + d;
      bl.push_back(d);
    end
    bl.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
    send_list(bl, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    recv_en = 1'b0;
    m_in = 0;
    sb.delete();
    hold_code = '0; hold_len = '0; hold_pay = '0; hold_err = '0;
    exp_busy = 0; busy_at = -1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Per-cycle comparison of every output against the model's expectations
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_err_valid", err_valid, 0);
      chk("rst_cmd_code", cmd_code, 0);
      chk("rst_cmd_len", cmd_len, 0);
      chk("rst_cmd_payload", cmd_payload, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("strobe_exclusive", cmd_valid & err_valid, 0);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("strobe_missing_due_cycle", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        cur = sb.pop_front();
        chk("cmd_valid", cmd_valid, cur.is_cmd);
        chk("err_valid", err_valid, !cur.is_cmd);
        if (cur.is_cmd) begin
          hold_code = cur.code;
          hold_len = cur.len;
          hold_pay = cur.pay;
        end else begin
          hold_err = cur.ecode;
        end
      end else begin
        chk("idle_cmd_valid", cmd_valid, 0);
        chk("idle_err_valid", err_valid, 0);
      end
      if (cyc == busy_at) exp_busy = busy_next;
      chk("busy", busy, exp_busy);
      chk("cmd_code", cmd_code, hold_code);
      chk("cmd_len", cmd_len, hold_len);
      chk("cmd_payload", cmd_payload, hold_pay);
      chk("err_code", err_code, hold_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    recv_en = 1'b0;
    recv_data = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    send_list('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}, 0);
    repeat (3) @(posedge clk);
    chk("pin1_code", cmd_code, 8'h01);
    chk("pin1_len", cmd_len, 4'd2);
    chk("pin1_payload", cmd_payload, 64'h2010);
    chk("pin1_model_payload", hold_pay, 64'h2010);

    send_list('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}, 0);
    repeat (3) @(posedge clk);
    chk("pin2_err_code", err_code, 2'd1);
    chk("pin2_code_kept", cmd_code, 8'h01);

    send_list('{8'hAA, 8'h05, 8'h09}, 0);
    repeat (3) @(posedge clk);
    chk("pin3_err_code", err_code, 2'd2);
    chk("pin3_not_busy", busy, 0);
    send_list('{8'hAA, 8'h07, 8'h00, 8'h07}, 0);
    repeat (3) @(posedge clk);
    chk("pin3_code", cmd_code, 8'h07);
    chk("pin3_len", cmd_len, 4'd0);
    chk("pin3_payload", cmd_payload, 64'h0);

    send_list('{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03}, 20);
    repeat (3) @(posedge clk);
    chk("pin4_code", cmd_code, 8'h03);
    chk("pin4_err_kept", err_code, 2'd2);

    send_list('{8'hAA, 8'h01, 8'h02, 8'h10}, 0);
    do_reset();
    send_list('{8'hAA, 8'h04, 8'h01, 8'h5A, 8'h5F}, 0);
    repeat (3) @(posedge clk);
    chk("pin5_code", cmd_code, 8'h04);
    chk("pin5_payload", cmd_payload, 64'h5A);

    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 4) send_frame(8'($urandom), int'($urandom_range(0, MAXL)), 0);
      else if (r <= 6) send_frame(8'($urandom), int'($urandom_range(0, MAXL)), 1);
      else if (r == 7) send_list('{HDR, 8'($urandom), 8'($urandom_range(MAXL + 1, 255))}, 0);
      else if (r == 8) send_list('{8'($urandom), 8'($urandom), 8'($urandom)}, 0);
      else begin
        send_list('{HDR, 8'($urandom)}, 0);
        do_reset();
      end
    end
    repeat (4) @(posedge clk);

    do_reset();
    send_list('{HDR, 8'h01}, 1);
`ifdef UART_CMD_TIMEOUT_EN
    cur.is_cmd = 0; cur.code = '0; cur.len = '0; cur.pay = '0;
    cur.ecode = 2'd3; cur.due = last_send + 102;
    sb.push_back(cur);
    m_in = 0;
    busy_next = 0;
    busy_at = last_send + 102;
    repeat (130) @(posedge clk);
    chk("tmo_err_code", err_code, 2'd3);
`else
    repeat (130) @(posedge clk);
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_err_code", err_code, 2'd0);
    do_reset();
`endif
    send_list('{8'hAA, 8'h02, 8'h01, 8'h33, 8'h36}, 0);
    repeat (3) @(posedge clk);
    chk("pin6_code", cmd_code, 8'h02);
    chk("pin6_payload", cmd_payload, 64'h33);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
